// File: rtl/mp_add_pkg.sv
// Shared types and helpers for the multi-precision add sequencer.
package mp_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Chunk index width; a single-chunk build still needs one bit.
  function automatic int idx_width(input int k);
    return (k <= 1) ? 1 : $clog2(k);
  endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational W-bit ripple-carry adder slice; also exposes the carry into the MSB.
module rca_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb
);

  logic [W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign co    = c[W];
  assign c_msb = c[W-1];

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision adder: one W-bit slice reused over K cycles, carry chained via carry_q.
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int W = 4,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W*K-1:0] a,
  input  logic [W*K-1:0] b,
  input  logic           cin,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W*K-1:0] sum,
  output logic           cout,
  output logic           ovf,
  output logic           busy
);

  localparam int IW = idx_width(K);

  state_t         state;
  state_t         state_next;
  logic [W*K-1:0] op_a;
  logic [W*K-1:0] op_b;
  logic [IW-1:0]  idx;
  logic           carry_q;
  int             base;
  logic [W-1:0]   chunk_a;
  logic [W-1:0]   chunk_b;
  logic [W-1:0]   slice_s;
  logic           slice_co;
  logic           slice_cmsb;
  logic           last;

  assign base    = int'(idx) * W;
  assign chunk_a = op_a[base +: W];
  assign chunk_b = op_b[base +: W];
  assign last    = (idx == IW'(K - 1));

  rca_slice #(.W(W)) u_slice (
    .a     (chunk_a),
    .b     (chunk_b),
    .ci    (carry_q),
    .s     (slice_s),
    .co    (slice_co),
    .c_msb (slice_cmsb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Handshake outputs decode only the state register, keeping inputs off any output path.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      idx     <= '0;
      carry_q <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a    <= a;
            op_b    <= b;
            carry_q <= cin;
            idx     <= '0;
            sum     <= '0;
          end
        end
        RUN: begin
          sum[base +: W] <= slice_s;
          carry_q        <= slice_co;
          if (last) begin
            cout <= slice_co;
            ovf  <= slice_co ^ slice_cmsb;
            idx  <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mp_add_seq.sv
// Scoreboard bench for mp_add_seq: W=4/K=4 main instance plus a W=8/K=1 instance.
module tb_mp_add_seq;

  localparam int W = 4;
  localparam int K = 4;
  localparam int N = W * K;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, busy;
  logic [N-1:0] a, b, sum;
  logic         in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, ovf1, busy1;
  logic [7:0]   a1, b1, sum1;

  always #5 clk = ~clk;

  mp_add_seq #(.W(W), .K(K)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  mp_add_seq #(.W(8), .K(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1)
  );

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t sb1[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   seen   = 0;
  bit   seen1  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Main monitor: latency measured on first out_valid, values compared on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_valid", 32'd1, 32'd0);
      end else begin
        if (!seen) begin
          checkOutput("latency", cyc - sb[0].acc, K);
          seen = 1;
        end
        if (out_ready) begin
          e = sb.pop_front();
          checkOutput("sum", sum, e.sum);
          checkOutput("cout", cout, e.cout);
          checkOutput("ovf", ovf, e.ovf);
          seen = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid1) begin
      if (sb1.size() == 0) begin
        checkOutput("k1_unexpected_valid", 32'd1, 32'd0);
      end else begin
        if (!seen1) begin
          checkOutput("k1_latency", cyc - sb1[0].acc, 1);
          seen1 = 1;
        end
        if (out_ready1) begin
          e = sb1.pop_front();
          checkOutput("k1_sum", sum1, e.sum);
          checkOutput("k1_cout", cout1, e.cout);
          checkOutput("k1_ovf", ovf1, e.ovf);
          seen1 = 0;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                               input bit push, input logic [15:0] es, input logic ec,
                               input logic eo);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    cin      = vc;
    @(posedge clk);
    #1;
    if (push) sb.push_back('{sum: es, cout: ec, ovf: eo, acc: cyc});
    in_valid = 1'b0;
    a        = 16'(($urandom));
    b        = 16'(($urandom));
    cin      = ~vc;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    cin        = 1'b0;
    out_ready  = 1'b1;
    in_valid1  = 1'b0;
    a1         = '0;
    b1         = '0;
    cin1       = 1'b0;
    out_ready1 = 1'b1;
    #2;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_sum", sum, 0);
    checkOutput("rst_cout", cout, 0);
    checkOutput("rst_ovf", ovf, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(16'h00FF, 16'h0001, 1'b0, 1, 16'h0100, 1'b0, 1'b0);
    drain();
    applyStimulus(16'hFFFF, 16'h0000, 1'b1, 1, 16'h0000, 1'b1, 1'b0);
    drain();
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1, 16'h8000, 1'b0, 1'b1);
    drain();
    applyStimulus(16'h8000, 16'h8000, 1'b0, 1, 16'h0000, 1'b1, 1'b1);
    drain();

    // Backpressure with an ignored request pulsed during RUN.
    out_ready = 1'b0;
    applyStimulus(16'h0F0F, 16'h0101, 1'b0, 1, 16'h1010, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    a        = 16'h1234;
    b        = 16'h1234;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_out_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold_sum", sum, 16'h1010);
      checkOutput("hold_out_valid", out_valid, 1);
      checkOutput("hold_in_ready", in_ready, 0);
      checkOutput("hold_busy", busy, 1);
    end
    out_ready = 1'b1;
    drain();

    // Reset in the middle of RUN discards the operation.
    applyStimulus(16'h1111, 16'h2222, 1'b0, 0, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("mid_in_ready", in_ready, 1);
    checkOutput("mid_out_valid", out_valid, 0);
    checkOutput("mid_busy", busy, 0);
    checkOutput("mid_sum", sum, 0);
    checkOutput("mid_cout", cout, 0);
    checkOutput("mid_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(16'h0003, 16'h0004, 1'b0, 1, 16'h0007, 1'b0, 1'b0);
    drain();

    // Single-chunk, 8-bit build.
    @(negedge clk);
    in_valid1 = 1'b1;
    a1        = 8'hFF;
    b1        = 8'h01;
    cin1      = 1'b0;
    @(posedge clk);
    #1;
    sb1.push_back('{sum: 16'h0000, cout: 1'b1, ovf: 1'b0, acc: cyc});
    in_valid1 = 1'b0;
    n = 0;
    while (sb1.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb1.size() != 0) begin
      checkOutput("k1_drain_timeout", sb1.size(), 32'd0);
      sb1.delete();
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
